// File: rtl/baggage_drop_seq_pkg.sv
// Shared types and constants for the sequential baggage-drop datapath.
package baggage_pkg;

    // Top-level sequencing states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_ROOT    = 2'd2,
        ST_RESULT  = 2'd3
    } state_e;

    // Seven-segment glyphs, bit6=g .. bit0=a, active-high
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_R     = 7'b1010000;
    localparam logic [6:0] SEG_O     = 7'b0111111;
    localparam logic [6:0] SEG_P     = 7'b1110011;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_L     = 7'b0111000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Result width of sqrt(height << 2*frac_bits); also the iteration count
    function automatic int unsigned root_w(input int unsigned sens_w,
                                           input int unsigned frac_bits);
        return sens_w / 2 + frac_bits;
    endfunction

endpackage

// File: rtl/baggage_drop_seq_iter_sqrt.sv
// Restoring digit-by-digit integer square root, one result bit per cycle, MSB first.
module iter_sqrt #(
    parameter int unsigned IN_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IN_W-1:0]   radicand,
    output logic              busy,
    output logic              done,
    output logic [IN_W/2-1:0] root
);

    localparam int unsigned OUT_W = IN_W / 2;
    localparam int unsigned REM_W = OUT_W + 2;
    localparam int unsigned CNT_W = $clog2(OUT_W + 1);

    logic [IN_W-1:0]  rad_q, rad_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [OUT_W-1:0] root_q, root_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [REM_W-1:0] rem_sh_c;
    logic [REM_W-1:0] trial_c;

    // Iteration: bring down two radicand bits, try subtracting (4*root + 1)
    always_comb begin
        rad_d    = rad_q;
        rem_d    = rem_q;
        root_d   = root_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rem_sh_c = {rem_q[REM_W-3:0], rad_q[IN_W-1 -: 2]};
        trial_c  = {root_q, 2'b01};
        if (!busy_q) begin
            if (start) begin
                rad_d  = radicand;
                rem_d  = '0;
                root_d = '0;
                cnt_d  = CNT_W'(OUT_W);
                busy_d = 1'b1;
            end
        end else begin
            rad_d = {rad_q[IN_W-3:0], 2'b00};
            if (rem_sh_c >= trial_c) begin
                rem_d  = rem_sh_c - trial_c;
                root_d = {root_q[OUT_W-2:0], 1'b1};
            end else begin
                rem_d  = rem_sh_c;
                root_d = {root_q[OUT_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign root = root_q;

endmodule

// File: rtl/baggage_drop_seq.sv
// Sequential baggage-drop: average valid sensors, fall time via iterative sqrt, display decision.
module baggage_drop_seq
    import baggage_pkg::*;
#(
    parameter int unsigned N_SENSORS = 4,
    parameter int unsigned SENS_W    = 8,
    parameter int unsigned FRAC_BITS = 4,
    parameter int unsigned T_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [N_SENSORS*SENS_W-1:0] sensors,
    input  logic [T_W-1:0]              t_lim,
    input  logic                        drop_en,
    output logic                        busy,
    output logic                        done,
    output logic [T_W-1:0]              t_act,
    output logic                        sensor_fault,
    output logic                        drop_activated,
    output logic [6:0]                  seven_seg1,
    output logic [6:0]                  seven_seg2,
    output logic [6:0]                  seven_seg3,
    output logic [6:0]                  seven_seg4
);

    localparam int unsigned ROOT_W = root_w(SENS_W, FRAC_BITS);
    localparam int unsigned RAD_W  = 2 * ROOT_W;
    localparam int unsigned SUM_W  = SENS_W + $clog2(N_SENSORS);
    localparam int unsigned CNT_W  = $clog2(N_SENSORS + 1);

    state_e                      state_q, state_d;
    logic [N_SENSORS*SENS_W-1:0] sens_q, sens_d;
    logic [T_W-1:0]              t_lim_q, t_lim_d;
    logic                        drop_en_q, drop_en_d;
    logic                        fault_q, fault_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [T_W-1:0]              t_act_q, t_act_d;
    logic                        sensor_fault_q, sensor_fault_d;
    logic                        drop_q, drop_d;
    logic [3:0][6:0]             seg_q, seg_d;

    logic [SUM_W-1:0]            sum_c;
    logic [CNT_W-1:0]            cnt_c;
    logic [SUM_W-1:0]            div_c;
    logic                        fault_c;
    logic [SENS_W-1:0]           height_c;
    logic [RAD_W-1:0]            radicand_c;
    logic [T_W-1:0]              t_act_c;
    logic                        drop_c;
    logic                        sqrt_start_c;
    logic                        sqrt_busy;
    logic                        sqrt_done;
    logic [ROOT_W-1:0]           sqrt_root;

    // Average of the non-zero latched sensors, scaled into the sqrt radicand
    always_comb begin
        sum_c = '0;
        cnt_c = '0;
        for (int i = 0; i < int'(N_SENSORS); i++) begin
            if (sens_q[i*SENS_W +: SENS_W] != '0) begin
                sum_c = sum_c + SUM_W'(sens_q[i*SENS_W +: SENS_W]);
                cnt_c = cnt_c + CNT_W'(1);
            end
        end
        fault_c    = (cnt_c == '0);
        div_c      = fault_c ? SUM_W'(1) : SUM_W'(cnt_c);
        height_c   = fault_c ? '0 : SENS_W'(sum_c / div_c);
        radicand_c = {height_c, {(2*FRAC_BITS){1'b0}}};
    end

    iter_sqrt #(
        .IN_W (RAD_W)
    ) u_sqrt (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (sqrt_start_c),
        .radicand (radicand_c),
        .busy     (sqrt_busy),
        .done     (sqrt_done),
        .root     (sqrt_root)
    );

    // Sequencing FSM; result registers load on the edge the root completes
    always_comb begin
        state_d        = state_q;
        sens_d         = sens_q;
        t_lim_d        = t_lim_q;
        drop_en_d      = drop_en_q;
        fault_d        = fault_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        t_act_d        = t_act_q;
        sensor_fault_d = sensor_fault_q;
        drop_d         = drop_q;
        seg_d          = seg_q;
        sqrt_start_c   = 1'b0;
        t_act_c        = T_W'(sqrt_root >> 1);
        drop_c         = drop_en_q & ~fault_q & (t_act_c >= t_lim_q);
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sens_d    = sensors;
                    t_lim_d   = t_lim;
                    drop_en_d = drop_en;
                    busy_d    = 1'b1;
                    state_d   = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                sqrt_start_c = 1'b1;
                fault_d      = fault_c;
                state_d      = ST_ROOT;
            end
            ST_ROOT: begin
                if (sqrt_done) begin
                    busy_d         = 1'b0;
                    done_d         = 1'b1;
                    t_act_d        = t_act_c;
                    sensor_fault_d = fault_q;
                    drop_d         = drop_c;
                    if (fault_q) begin
                        seg_d = {SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH};
                    end else if (drop_c) begin
                        seg_d = {SEG_D, SEG_R, SEG_O, SEG_P};
                    end else begin
                        seg_d = {SEG_C, SEG_O, SEG_L, SEG_D};
                    end
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            sens_q         <= '0;
            t_lim_q        <= '0;
            drop_en_q      <= 1'b0;
            fault_q        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            t_act_q        <= '0;
            sensor_fault_q <= 1'b0;
            drop_q         <= 1'b0;
            seg_q          <= {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK};
        end else begin
            state_q        <= state_d;
            sens_q         <= sens_d;
            t_lim_q        <= t_lim_d;
            drop_en_q      <= drop_en_d;
            fault_q        <= fault_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            t_act_q        <= t_act_d;
            sensor_fault_q <= sensor_fault_d;
            drop_q         <= drop_d;
            seg_q          <= seg_d;
        end
    end

    // The root engine must be running or just finishing while the FSM waits on it
    assert property (@(posedge clk) disable iff (!rst_n)
                     (state_q == ST_ROOT) |-> (sqrt_busy || sqrt_done));

    // A t_act narrower than the root silently loses MSBs
    if (T_W < ROOT_W) begin : g_tw_chk
        assert property (@(posedge clk) 1'b0)
            else $error("baggage_drop_seq: T_W narrower than root width");
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign t_act          = t_act_q;
    assign sensor_fault   = sensor_fault_q;
    assign drop_activated = drop_q;
    assign seven_seg1     = seg_q[3];
    assign seven_seg2     = seg_q[2];
    assign seven_seg3     = seg_q[1];
    assign seven_seg4     = seg_q[0];

endmodule

// File: tb/tb_baggage_drop_seq.sv
// Scoreboard bench for baggage_drop_seq with a behavioural reference model.
module tb_baggage_drop_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] sensors;
    logic [15:0] t_lim;
    logic        drop_en;
    logic        busy;
    logic        done;
    logic [15:0] t_act;
    logic        sensor_fault;
    logic        drop_activated;
    logic [6:0]  seven_seg1, seven_seg2, seven_seg3, seven_seg4;

    baggage_drop_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .sensors        (sensors),
        .t_lim          (t_lim),
        .drop_en        (drop_en),
        .busy           (busy),
        .done           (done),
        .t_act          (t_act),
        .sensor_fault   (sensor_fault),
        .drop_activated (drop_activated),
        .seven_seg1     (seven_seg1),
        .seven_seg2     (seven_seg2),
        .seven_seg3     (seven_seg3),
        .seven_seg4     (seven_seg4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned t_act;
        bit          fault;
        bit          drop;
        logic [6:0]  s1, s2, s3, s4;
        int unsigned done_cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        last_exp;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clk) cyc++;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endfunction

    // Reference: mean of non-zero readings, fall time = floor(sqrt(h*256))/2 in Q.4
    function automatic exp_t model(input int unsigned s[4], input int unsigned tl, input bit de,
                                   input int unsigned dc);
        exp_t        e;
        int unsigned sum = 0;
        int unsigned cnt = 0;
        int unsigned h;
        int unsigned rad;
        int unsigned r = 0;
        foreach (s[i]) begin
            if (s[i] != 0) begin
                sum += s[i];
                cnt++;
            end
        end
        h = (cnt == 0) ? 0 : sum / cnt;
        rad = h * 256;
        while ((r + 1) * (r + 1) <= rad) r++;
        e.t_act = r / 2;
        e.fault = (cnt == 0);
        e.drop  = de && !e.fault && (e.t_act >= tl);
        if (e.fault) begin
            e.s1 = 7'b1000000; e.s2 = 7'b1000000; e.s3 = 7'b1000000; e.s4 = 7'b1000000;
        end else if (e.drop) begin
            e.s1 = 7'b1011110; e.s2 = 7'b1010000; e.s3 = 7'b0111111; e.s4 = 7'b1110011;
        end else begin
            e.s1 = 7'b0111001; e.s2 = 7'b0111111; e.s3 = 7'b0111000; e.s4 = 7'b1011110;
        end
        e.done_cyc = dc;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1 && done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("latency_cycle", 32'(cyc), 32'(e.done_cyc));
                    check("t_act", 32'(t_act), 32'(e.t_act));
                    check("sensor_fault", 32'(sensor_fault), 32'(e.fault));
                    check("drop_activated", 32'(drop_activated), 32'(e.drop));
                    check("busy_with_done", 32'(busy), 32'(0));
                    check("seg1", 32'(seven_seg1), 32'(e.s1));
                    check("seg2", 32'(seven_seg2), 32'(e.s2));
                    check("seg3", 32'(seven_seg3), 32'(e.s3));
                    check("seg4", 32'(seven_seg4), 32'(e.s4));
                    last_exp = e;
                end
            end
        end
    end

    task automatic wait_done();
        bit seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout got=none expected=done within 20 cycles");
        end
    endtask

    task automatic run_one(input int unsigned s0, input int unsigned s1, input int unsigned s2,
                           input int unsigned s3, input int unsigned tl, input bit de,
                           input bit scramble, input bit extra_start);
        int unsigned sv[4];
        sv = '{s0, s1, s2, s3};
        @(negedge clk);
        sensors = {8'(s3), 8'(s2), 8'(s1), 8'(s0)};
        t_lim   = 16'(tl);
        drop_en = de;
        start   = 1'b1;
        exp_q.push_back(model(sv, tl, de, cyc + 11));
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'(1));
        if (scramble) begin
            sensors = $urandom;
            t_lim   = 16'($urandom);
            drop_en = 1'($urandom);
        end
        if (extra_start) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
        repeat (2) @(negedge clk);
        check("hold_t_act", 32'(t_act), 32'(last_exp.t_act));
        check("hold_seg1", 32'(seven_seg1), 32'(last_exp.s1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
        check({tag, "_t_act"}, 32'(t_act), 32'(0));
        check({tag, "_fault"}, 32'(sensor_fault), 32'(0));
        check({tag, "_drop"}, 32'(drop_activated), 32'(0));
        check({tag, "_segs"}, 32'({seven_seg1, seven_seg2, seven_seg3, seven_seg4}), 32'(0));
    endtask

    // Hard stop if the stimulus itself ever stalls
    initial begin
        #300000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned rs[4];
        rst_n   = 1'b0;
        start   = 1'b0;
        sensors = '0;
        t_lim   = '0;
        drop_en = 1'b0;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_one(100, 100, 100, 100, 80, 1, 0, 0);
        run_one(100, 100, 100, 100, 81, 1, 0, 0);
        run_one(0, 50, 0, 50, 56, 1, 1, 0);
        run_one(0, 50, 0, 50, 57, 1, 0, 0);
        run_one(0, 0, 0, 0, 0, 1, 0, 0);
        run_one(200, 200, 200, 200, 0, 0, 0, 0);
        run_one(1, 0, 0, 0, 0, 1, 0, 0);
        run_one(255, 255, 255, 255, 127, 1, 1, 1);

        // Abort a run mid-root: outputs clear at once, no done
        run_one(100, 100, 100, 100, 80, 1, 0, 0);
        @(negedge clk);
        sensors = {8'd90, 8'd90, 8'd90, 8'd90};
        t_lim   = 16'd10;
        drop_en = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_no_done_t_act", 32'(t_act), 32'(0));

        run_one(0, 50, 0, 50, 56, 1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++)
                rs[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
            run_one(rs[0], rs[1], rs[2], rs[3], $urandom_range(0, 130), 1'($urandom),
                    1'($urandom), ($urandom_range(0, 4) == 0));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
